// File: rtl/wraddr_sequencer_if.sv
// Signal bundle between the IRS write-address sequencer and its controller:
// run/trigger/release requests in, address stream and hold status out.
interface wraddr_sequencer_if #(
   parameter int WIDTH = 10
);
   logic             enable_i;
   logic             trig_i;
   logic             release_i;
   logic [1:0]       release_slot_i;
   logic [WIDTH-1:0] wraddr_o;
   logic             wraddr_ce_o;
   logic             trig_ack_o;
   logic [1:0]       trig_slot_o;
   logic [WIDTH-1:0] trig_base_o;
   logic             trig_drop_o;
   logic [3:0]       holds_active_o;
   logic             holds_full_o;

   modport master (
      output enable_i, trig_i, release_i, release_slot_i,
      input  wraddr_o, wraddr_ce_o, trig_ack_o, trig_slot_o, trig_base_o,
             trig_drop_o, holds_active_o, holds_full_o
   );

   modport slave (
      input  enable_i, trig_i, release_i, release_slot_i,
      output wraddr_o, wraddr_ce_o, trig_ack_o, trig_slot_o, trig_base_o,
             trig_drop_o, holds_active_o, holds_full_o
   );
endinterface

// File: rtl/wraddr_sequencer.sv
// Walks the IRS write-block ring at a fixed dwell, pulsing CE per new address,
// and steps over blocks locked by up to four trigger hold windows.
module wraddr_sequencer #(
   parameter int WIDTH   = 10,
   parameter int DWELL   = 4,
   parameter int PRETRIG = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   wraddr_sequencer_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_SKIP = 2'd3;

   localparam logic [WIDTH-1:0] ADDR_ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] PRETRIG_W  = WIDTH'(PRETRIG);
   localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] wraddr_reg, wraddr_next;
   logic [WIDTH-1:0] cand_reg, cand_next;
   logic [7:0]       dwell_reg, dwell_next;
   logic             ce_reg, ce_next;

   logic [3:0]       active_reg, active_next;
   logic             full_reg;
   logic             ack_reg;
   logic [1:0]       slot_out_reg;
   logic [WIDTH-1:0] base_out_reg;
   logic             drop_reg;

   logic [WIDTH-1:0] test_addr;
   logic [3:0]       slot_hit;
   logic             test_held;
   logic [WIDTH-1:0] trig_base;
   logic [3:0]       release_mask;
   logic [3:0]       active_rel;
   logic [1:0]       free_slot;
   logic             have_free;
   logic             grant;
   logic             drop;

   // RUN probes the block after the current one; SKIP probes the running candidate.
   assign test_addr = (state_reg == ST_SKIP) ? cand_reg : wraddr_reg + ADDR_ONE;
   assign trig_base = wraddr_reg - PRETRIG_W + ADDR_ONE;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slot
         logic [WIDTH-1:0] base_reg;
         logic [WIDTH-1:0] offset;

         // Modular distance from the window start covers windows straddling the wrap.
         assign offset       = test_addr - base_reg;
         assign slot_hit[gi] = active_reg[gi] && (offset < PRETRIG_W);

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               base_reg <= '0;
            end else if (grant && (free_slot == 2'(gi))) begin
               base_reg <= trig_base;
            end
         end
      end
   endgenerate

   assign test_held = |slot_hit;

   // Release lands before allocation so a slot freed this cycle can be regranted.
   always_comb begin
      release_mask = 4'b0000;
      if (bus.release_i) begin
         release_mask[bus.release_slot_i] = 1'b1;
      end
      active_rel = active_reg & ~release_mask;
      free_slot  = 2'd0;
      have_free  = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (!active_rel[i]) begin
            free_slot = 2'(i);
            have_free = 1'b1;
         end
      end
      grant       = bus.trig_i && have_free;
      drop        = bus.trig_i && !have_free;
      active_next = active_rel;
      if (grant) begin
         active_next[free_slot] = 1'b1;
      end
   end

   always_comb begin
      state_next  = state_reg;
      wraddr_next = wraddr_reg;
      cand_next   = cand_reg;
      dwell_next  = dwell_reg;
      ce_next     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            dwell_next = 8'd0;
            if (bus.enable_i) begin
               state_next = ST_LOAD;
               ce_next    = 1'b1;
            end
         end
         ST_LOAD: begin
            // The LOAD cycle is the first dwell cycle of the re-presented block.
            if (!bus.enable_i) begin
               state_next = ST_IDLE;
               dwell_next = 8'd0;
            end else begin
               state_next = ST_RUN;
               dwell_next = 8'd1;
            end
         end
         ST_RUN: begin
            if (!bus.enable_i) begin
               state_next = ST_IDLE;
               dwell_next = 8'd0;
            end else if (dwell_reg == DWELL_LAST) begin
               if (!test_held) begin
                  wraddr_next = test_addr;
                  ce_next     = 1'b1;
                  dwell_next  = 8'd0;
               end else begin
                  state_next = ST_SKIP;
                  cand_next  = test_addr + ADDR_ONE;
               end
            end else begin
               dwell_next = dwell_reg + 8'd1;
            end
         end
         ST_SKIP: begin
            if (!bus.enable_i) begin
               state_next = ST_IDLE;
               dwell_next = 8'd0;
            end else if (!test_held) begin
               state_next  = ST_RUN;
               wraddr_next = test_addr;
               ce_next     = 1'b1;
               dwell_next  = 8'd0;
            end else begin
               cand_next = cand_reg + ADDR_ONE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            dwell_next = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= ST_IDLE;
         wraddr_reg   <= '0;
         cand_reg     <= '0;
         dwell_reg    <= 8'd0;
         ce_reg       <= 1'b0;
         active_reg   <= 4'b0000;
         full_reg     <= 1'b0;
         ack_reg      <= 1'b0;
         slot_out_reg <= 2'd0;
         base_out_reg <= '0;
         drop_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wraddr_reg   <= wraddr_next;
         cand_reg     <= cand_next;
         dwell_reg    <= dwell_next;
         ce_reg       <= ce_next;
         active_reg   <= active_next;
         full_reg     <= &active_next;
         ack_reg      <= grant;
         slot_out_reg <= grant ? free_slot : 2'd0;
         base_out_reg <= grant ? trig_base : '0;
         drop_reg     <= drop;
      end
   end

   assign bus.wraddr_o       = wraddr_reg;
   assign bus.wraddr_ce_o    = ce_reg;
   assign bus.trig_ack_o     = ack_reg;
   assign bus.trig_slot_o    = slot_out_reg;
   assign bus.trig_base_o    = base_out_reg;
   assign bus.trig_drop_o    = drop_reg;
   assign bus.holds_active_o = active_reg;
   assign bus.holds_full_o   = full_reg;

endmodule

// File: tb/tb_wraddr_sequencer.sv
// Scoreboard bench for wraddr_sequencer: a block-level model predicts CE events,
// hold grants and status per cycle; a negedge monitor pops and compares them.
module tb_wraddr_sequencer;

   localparam int WIDTH   = 10;
   localparam int DWELL   = 4;
   localparam int PRETRIG = 4;
   localparam int RING    = 1 << WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wraddr_sequencer_if #(.WIDTH(WIDTH)) bus ();

   wraddr_sequencer #(.WIDTH(WIDTH), .DWELL(DWELL), .PRETRIG(PRETRIG)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct { int stamp; int addr; } ce_t;
   typedef struct { int stamp; bit drop; int slot; int base; } tr_t;
   typedef struct { int stamp; int addr; int holds; bit full; } st_t;

   ce_t ce_q[$];
   tr_t tr_q[$];
   st_t st_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: current block, cycles spent on it, next block to try, hold table.
   bit m_active = 0;
   int m_addr   = 0;
   int m_el     = 0;
   int m_probe  = 1;
   bit m_hact[4];
   int m_hbase[4];

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic bit is_held(int b);
      for (int k = 0; k < 4; k++)
         if (m_hact[k] && (((b - m_hbase[k] + RING) % RING) < PRETRIG)) return 1'b1;
      return 1'b0;
   endfunction

   // Drive one cycle of inputs and predict what the DUT shows next cycle.
   task automatic step(bit r, bit en, bit tg, bit rl, int rs);
      int  old_addr;
      bit  ce;
      int  hb;
      bit  got;
      @(posedge clk);
      #1;
      cyc++;
      rst                = r;
      bus.enable_i       = en;
      bus.trig_i         = tg;
      bus.release_i      = rl;
      bus.release_slot_i = 2'(rs);
      ce                 = 1'b0;
      if (r) begin
         m_active = 0; m_addr = 0; m_el = 0; m_probe = 1;
         for (int k = 0; k < 4; k++) begin m_hact[k] = 0; m_hbase[k] = 0; end
      end else begin
         old_addr = m_addr;
         if (!m_active) begin
            if (en) begin
               m_active = 1; m_el = 0; m_probe = (m_addr + 1) % RING; ce = 1'b1;
            end
         end else if (!en) begin
            m_active = 0;
         end else if (m_el < DWELL - 1) begin
            m_el++;
         end else if (!is_held(m_probe)) begin
            m_addr = m_probe; m_el = 0; m_probe = (m_probe + 1) % RING; ce = 1'b1;
         end else begin
            m_probe = (m_probe + 1) % RING; m_el++;
         end
         if (rl) m_hact[rs] = 0;
         if (tg) begin
            got = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (!got && !m_hact[k]) begin
                  got = 1'b1;
                  m_hact[k]  = 1;
                  m_hbase[k] = (old_addr - PRETRIG + 1 + RING) % RING;
                  tr_q.push_back('{stamp: cyc + 1, drop: 1'b0, slot: k, base: m_hbase[k]});
               end
            end
            if (!got) tr_q.push_back('{stamp: cyc + 1, drop: 1'b1, slot: 0, base: 0});
         end
         if (ce) ce_q.push_back('{stamp: cyc + 1, addr: m_addr});
      end
      hb = 0;
      for (int k = 0; k < 4; k++) if (m_hact[k]) hb |= (1 << k);
      st_q.push_back('{stamp: cyc + 1, addr: m_addr, holds: hb, full: (hb == 15)});
   endtask

   task automatic run_until(int target, string tag);
      int n = 0;
      while (!(m_active && m_addr == target && m_el == 0) && n < 10000) begin
         step(0, 1, 0, 0, 0);
         n++;
      end
      chk(tag, (n < 10000) ? 1 : 0, 1);
   endtask

   // Monitor: compares whatever the DUT presents against the model queues.
   initial begin
      st_t s;
      ce_t c;
      tr_t t;
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            if (st_q.size() > 0 && st_q[0].stamp == cyc) begin
               s = st_q.pop_front();
               chk("wraddr", int'(bus.wraddr_o), s.addr);
               chk("holds_active", int'(bus.holds_active_o), s.holds);
               chk("holds_full", int'(bus.holds_full_o), int'(s.full));
            end
            while (ce_q.size() > 0 && ce_q[0].stamp < cyc) begin
               c = ce_q.pop_front();
               chk("ce_missing_addr", -1, c.addr);
            end
            if (bus.wraddr_ce_o === 1'b1) begin
               if (ce_q.size() > 0 && ce_q[0].stamp == cyc) begin
                  c = ce_q.pop_front();
                  chk("ce_addr", int'(bus.wraddr_o), c.addr);
               end else begin
                  chk("ce_unexpected", 1, 0);
               end
            end
            while (tr_q.size() > 0 && tr_q[0].stamp < cyc) begin
               t = tr_q.pop_front();
               chk("trig_resp_missing", 0, 1);
            end
            if (bus.trig_ack_o === 1'b1 || bus.trig_drop_o === 1'b1) begin
               if (tr_q.size() > 0 && tr_q[0].stamp == cyc) begin
                  t = tr_q.pop_front();
                  chk("trig_drop", int'(bus.trig_drop_o), int'(t.drop));
                  chk("trig_ack", int'(bus.trig_ack_o), int'(!t.drop));
                  if (!t.drop) begin
                     chk("trig_slot", int'(bus.trig_slot_o), t.slot);
                     chk("trig_base", int'(bus.trig_base_o), t.base);
                  end
               end else begin
                  chk("trig_unexpected", 1, 0);
               end
            end
         end
      end
   end

   initial begin
      bit en_state;
      int n;
      bus.enable_i       = 1'b0;
      bus.trig_i         = 1'b0;
      bus.release_i      = 1'b0;
      bus.release_slot_i = 2'd0;
      for (int k = 0; k < 4; k++) begin m_hact[k] = 0; m_hbase[k] = 0; end

      repeat (3) step(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("rst_wraddr", int'(bus.wraddr_o), 0);
      chk("rst_ce", int'(bus.wraddr_ce_o), 0);
      chk("rst_holds", int'(bus.holds_active_o), 0);
      chk("rst_ack", int'(bus.trig_ack_o), 0);
      chk("rst_drop", int'(bus.trig_drop_o), 0);

      // Hold at block 10: window 7..10, skipped on the next lap.
      run_until(10, "reach_10");
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      @(negedge clk);
      chk("ack_at_10", int'(bus.trig_ack_o), 1);
      chk("slot_at_10", int'(bus.trig_slot_o), 0);
      chk("base_at_10", int'(bus.trig_base_o), 7);
      run_until(6, "reach_6");
      run_until(11, "reach_11");

      // Hold at block 2: window 1023..2 straddles the wrap.
      run_until(2, "reach_2");
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      @(negedge clk);
      chk("slot_at_2", int'(bus.trig_slot_o), 1);
      chk("base_at_2", int'(bus.trig_base_o), 1023);
      run_until(1022, "reach_1022");
      run_until(3, "reach_3");

      // Enable drop freezes the address; re-enable re-presents it.
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);

      // Free everything, then four grants and a refusal.
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, 0, 0);
         step(0, 1, 0, 0, 0);
         @(negedge clk);
         if (i < 4) chk("fill_slot", int'(bus.trig_slot_o), i);
         else       chk("fill_drop", int'(bus.trig_drop_o), 1);
      end
      chk("full_flag", int'(bus.holds_full_o), 1);
      chk("full_mask", int'(bus.holds_active_o), 15);

      // Release of slot 2 and a trigger together regrant slot 2.
      step(0, 1, 1, 1, 2);
      step(0, 1, 0, 0, 0);
      @(negedge clk);
      chk("regrant_ack", int'(bus.trig_ack_o), 1);
      chk("regrant_slot", int'(bus.trig_slot_o), 2);
      chk("regrant_full", int'(bus.holds_full_o), 1);

      // Reset while skipping held blocks.
      n = 0;
      while (!(m_active && m_el >= DWELL) && n < 6000) begin
         step(0, 1, 0, 0, 0);
         n++;
      end
      chk("reach_skip", (n < 6000) ? 1 : 0, 1);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("skip_rst_wraddr", int'(bus.wraddr_o), 0);
      chk("skip_rst_ce", int'(bus.wraddr_ce_o), 0);
      chk("skip_rst_holds", int'(bus.holds_active_o), 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      @(negedge clk);
      chk("reload_ce", int'(bus.wraddr_ce_o), 1);
      chk("reload_addr", int'(bus.wraddr_o), 0);

      // Randomised traffic.
      en_state = 1'b1;
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(0, 299) == 0) en_state = ~en_state;
         step(($urandom_range(0, 2999) == 0), en_state,
              ($urandom_range(0, 149) == 0), ($urandom_range(0, 99) == 0),
              int'($urandom_range(0, 3)));
      end

      repeat (3) step(0, 1, 0, 0, 0);
      @(negedge clk);
      foreach (ce_q[i]) if (ce_q[i].stamp <= cyc) chk("ce_left", 1, 0);
      foreach (tr_q[i]) if (tr_q[i].stamp <= cyc) chk("trig_left", 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wraddr_sequencer.md
Name: wraddr_sequencer

Overview:
Generates the IRS write-block address sequence that drives the write-address output stage (the IOB FDE plus IODELAY2 delay path). It advances the address through a 2^WIDTH-block ring at a programmable dwell rate and emits a one-cycle clock-enable with each new address. On trigger it locks a window of recently written blocks against overwrite, and the sequencer skips those blocks until readout releases them. Up to four hold windows are tracked.

Parameters:
WIDTH, 10, address width; the ring is 2^WIDTH blocks, indices 0..2^WIDTH-1.
DWELL, 4, clocks each block is presented before advancing; legal range 2..255.
PRETRIG, 4, blocks per hold window; the window ends at the block current at trigger. Constraint: 4*PRETRIG < 2^WIDTH.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  run sequencer; low = freeze address
trig_i  in  1  single-cycle hold request
release_i  in  1  single-cycle release strobe
release_slot_i  in  2  slot released with release_i
wraddr_o  out  WIDTH  write block address to the output stage
wraddr_ce_o  out  1  one-cycle pulse: wraddr_o is new; drives the FDE CE
trig_ack_o  out  1  one-cycle pulse: hold granted
trig_slot_o  out  2  granted slot; valid with trig_ack_o
trig_base_o  out  WIDTH  first block of the granted window; valid with trig_ack_o
trig_drop_o  out  1  one-cycle pulse: hold refused, all slots busy
holds_active_o  out  4  per-slot active bits
holds_full_o  out  1  all four slots active

Behaviour:
- Reset (synchronous, takes priority over all other inputs): every output is 0, all hold slots are cleared, the dwell counter is 0, and the state is IDLE. Reset asserted mid-SKIP or mid-RUN takes effect on the next edge and leaves no partial state.
- States are IDLE, LOAD, RUN and SKIP.
  - IDLE: ce is low. If enable_i=1, go to LOAD.
  - LOAD: pulse ce with the current wraddr_o, which is 0 after reset. Clear the dwell counter. Go to RUN.
  - RUN: increment the dwell counter each cycle. At DWELL-1, set candidate = (wraddr_o+1) mod 2^WIDTH.
    - If the candidate is not held: wraddr_o <= candidate, pulse ce, clear the dwell counter, stay in RUN.
    - If the candidate is held: go to SKIP.
  - SKIP: each cycle, candidate <= candidate+1 mod 2^WIDTH. The first unheld candidate is loaded as in RUN, with a ce pulse and a return to RUN. ce stays low while skipping. The parameter constraint guarantees termination.
- Hold test: block b is held if active[k] and ((b - base[k]) mod 2^WIDTH) < PRETRIG, for any slot k. All subtraction is modulo 2^WIDTH.
- enable_i=0 in RUN or SKIP:
  - Next state is IDLE; wraddr_o is frozen.
  - The dwell count is discarded and ce is not pulsed.
  - Holds are preserved.
  - Re-enabling re-enters LOAD, which re-presents the frozen address. A frozen address inside a hold window is re-presented anyway.
- Trigger, when trig_i=1:
  - Window base = (wraddr_o - PRETRIG + 1) mod 2^WIDTH, using wraddr_o before any same-cycle update.
  - Next cycle, choose the lowest free slot: set it active, store the base, and pulse trig_ack_o with trig_slot_o and trig_base_o.
  - If no slot is free, pulse trig_drop_o instead; no state changes.
  - Triggers are accepted in any state, including IDLE.
- Release: release_i clears active[release_slot_i]. Releasing an inactive slot is ignored.
- Simultaneous release and trigger in the same cycle: the release is applied first, so the freed slot is eligible for the trigger.
- Holds take effect for advance decisions one cycle after trig_i.
- holds_active_o and holds_full_o are registered and reflect slot state.

Test Plan:
- Reset, then enable_i=1 at cycle 0 → ce pulse with wraddr=0 at cycle 1; ce pulse with 1 at cycle 5; ce pulses every 4 cycles thereafter; 1023 wraps to 0.
- trig_i while wraddr=10 → next cycle trig_ack_o=1, slot=0, base=7. On the following lap, 6 is followed by 11; the ce for 11 comes 4+4 cycles after the ce for 6 (4 skip cycles).
- Trigger at wraddr=2 → base=1023. On the next lap, 1022 is followed by 3 (wrap-straddling window skipped).
- Five triggers with no release → acks for slots 0,1,2,3; fifth gives trig_drop_o=1; holds_full_o=1, holds_active_o=4'b1111.
- With holds full, release_i with slot 2 and trig_i in the same cycle → trig_ack_o with slot=2; holds_full_o stays 1.
- Assert rst_i during SKIP → next cycle wraddr_o=0, ce=0, holds_active_o=0; re-enable → LOAD presents 0.
